// File: rtl/uart_rx_oversampler.sv
// UART receive oversampler: synchronises R_IN, captures NSAMP samples around the
// bit centre (or one centre sample) and emits a registered majority-voted bit.
module uart_rx_oversampler #(
  parameter int PRESC_W     = 6,
  parameter int NSAMP       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               R_IN,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [PRESC_W-1:0] edge_cnt,
  input  logic               dat_samp_en,
  input  logic               single_mode,
  output logic               sampled_bit,
  output logic               sample_valid,
  output logic               noise_flag,
  output logic               cfg_err
);

  localparam int                 CW   = $clog2(NSAMP + 1);
  localparam logic [PRESC_W-1:0] SPAN = PRESC_W'(NSAMP - 1);
  localparam logic [CW-1:0]      FULL = CW'(NSAMP - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rin_s;
  logic [NSAMP-1:0]       samp_q;
  logic [CW-1:0]          cnt_q;
  logic [PRESC_W-1:0]     last_idx_q;

  logic [PRESC_W-1:0] centre, first_slot;
  logic               eff_single, in_slot, at_c, cap, done;
  logic [NSAMP-1:0]   window;
  logic [CW-1:0]      ones;
  logic               maj, all_eq;

  assign rin_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= R_IN;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // A too-narrow majority window falls back to a single centre sample.
  always_comb begin
    centre     = prescale >> 1;
    cfg_err    = !single_mode && (centre < SPAN);
    eff_single = single_mode | cfg_err;
    first_slot = eff_single ? centre : centre - SPAN;
    in_slot    = (edge_cnt >= first_slot) && (edge_cnt <= centre);
    at_c       = (edge_cnt == centre);
    cap        = dat_samp_en && in_slot && (edge_cnt != last_idx_q);
    done       = cap && at_c && (cnt_q == (eff_single ? '0 : FULL));
    window     = {samp_q[NSAMP-2:0], rin_s};
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < NSAMP; i++) ones = ones + CW'(window[i]);
    maj    = ones > CW'(NSAMP / 2);
    all_eq = (ones == '0) || (ones == CW'(NSAMP));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp_q     <= '1;
      cnt_q      <= '0;
      last_idx_q <= '1;
    end else begin
      if (cap) samp_q <= window;
      if (!dat_samp_en)
        cnt_q <= '0;
      else if (edge_cnt == '0 && first_slot != '0)
        cnt_q <= '0;
      else if (cap)
        cnt_q <= at_c ? '0 : cnt_q + 1'b1;
      // Index all-ones is never a slot, so it marks "nothing captured yet".
      if (!dat_samp_en || !in_slot)
        last_idx_q <= '1;
      else if (cap)
        last_idx_q <= edge_cnt;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
      noise_flag   <= 1'b0;
    end else begin
      sample_valid <= done;
      if (done) begin
        sampled_bit <= eff_single ? rin_s : maj;
        noise_flag  <= eff_single ? 1'b0 : !all_eq;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Scoreboard bench for uart_rx_oversampler: a 3-sample and a 5-sample instance,
// expected pulses queued as each bit is driven and checked as pulses arrive.
module tb_uart_rx_oversampler;

  localparam int SYNC = 2;

  typedef struct {
    logic b;
    logic n;
    int   c;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       r3, en3, sm3, r5, en5, sm5;
  logic [5:0] ps3, ec3, ps5, ec5;
  logic       sb3, sv3, nf3, ce3, sb5, sv5, nf5, ce5;

  int   total = 0, bad = 0, cyc_n = 0;
  exp_t q3[$], q5[$];

  uart_rx_oversampler #(.PRESC_W(6), .NSAMP(3), .SYNC_STAGES(SYNC)) u3 (
    .CLK(CLK), .RST(RST), .R_IN(r3), .prescale(ps3), .edge_cnt(ec3),
    .dat_samp_en(en3), .single_mode(sm3), .sampled_bit(sb3),
    .sample_valid(sv3), .noise_flag(nf3), .cfg_err(ce3));

  uart_rx_oversampler #(.PRESC_W(6), .NSAMP(5), .SYNC_STAGES(SYNC)) u5 (
    .CLK(CLK), .RST(RST), .R_IN(r5), .prescale(ps5), .edge_cnt(ec5),
    .dat_samp_en(en5), .single_mode(sm5), .sampled_bit(sb5),
    .sample_valid(sv5), .noise_flag(nf5), .cfg_err(ce5));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp_v);
    end
  endtask

  task automatic push(input int sel, input logic b, input logic n, input int c);
    exp_t e;
    e.b = b; e.n = n; e.c = c;
    if (sel == 3) q3.push_back(e);
    else          q5.push_back(e);
  endtask

  task automatic cyc(input int sel, input logic r, input int ec, input logic en);
    if (sel == 3) begin r3 = r; ec3 = 6'(ec); en3 = en; end
    else          begin r5 = r; ec5 = 6'(ec); en5 = en; end
    @(posedge CLK); #1;
  endtask

  // v[i] is the line value wanted at rin_s when edge_cnt=i; R_IN leads by SYNC.
  task automatic run_bit(input int sel, input int ps, input logic [31:0] v,
                         input logic [31:0] en_off, input int stall,
                         input logic pulse, input logic eb, input logic en_);
    int c;
    int reps;
    logic r;
    c = ps / 2;
    cyc(sel, v[0], 0, 1'b0);
    cyc(sel, v[1], 0, 1'b0);
    for (int j = 0; j < ps; j++) begin
      reps = (j == c) ? stall : 0;
      for (int k = 0; k <= reps; k++) begin
        r = (j + SYNC < 32) ? v[j+SYNC] : 1'b1;
        if (pulse && j == c && k == 0) push(sel, eb, en_, cyc_n + 1);
        cyc(sel, r, j, !en_off[j]);
      end
    end
    cyc(sel, 1'b1, 0, 1'b0);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (sv3 === 1'b1) begin
      if (q3.size() == 0) chk("spur3", sv3, 0);
      else begin
        e = q3.pop_front();
        chk("bit3", sb3, e.b); chk("nf3", nf3, e.n); chk("lat3", cyc_n, e.c);
      end
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (sv5 === 1'b1) begin
      if (q5.size() == 0) chk("spur5", sv5, 0);
      else begin
        e = q5.pop_front();
        chk("bit5", sb5, e.b); chk("nf5", nf5, e.n); chk("lat5", cyc_n, e.c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    RST = 1'b0;
    r3 = 1'b1; en3 = 1'b0; sm3 = 1'b0; ps3 = 6'd8;  ec3 = '0;
    r5 = 1'b1; en5 = 1'b0; sm5 = 1'b0; ps5 = 6'd16; ec5 = '0;
    #12;
    chk("rst_sb3", sb3, 1); chk("rst_sv3", sv3, 0); chk("rst_nf3", nf3, 0);
    chk("rst_sb5", sb5, 1); chk("rst_sv5", sv5, 0); chk("rst_nf5", nf5, 0);
    chk("rst_ce3", ce3, 0); chk("rst_ce5", ce5, 0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // 3-sample instance, prescale 8: slots 2,3,4
    run_bit(3, 8, 32'h0,        32'h0, 0, 1'b1, 1'b0, 1'b0);
    run_bit(3, 8, 32'h14,       32'h0, 0, 1'b1, 1'b1, 1'b1);
    run_bit(3, 8, 32'h08,       32'h0, 0, 1'b1, 1'b0, 1'b1);
    run_bit(3, 8, 32'hFFFFFFFF, 32'h0, 0, 1'b1, 1'b1, 1'b0);
    run_bit(3, 8, 32'h0,        32'h8, 0, 1'b0, 1'b0, 1'b0);
    chk("hold_en_drop", sb3, 1); chk("hold_nf_drop", nf3, 0);
    run_bit(3, 8, 32'h0,        32'h7, 0, 1'b0, 1'b0, 1'b0);
    chk("hold_late_en", sb3, 1);
    run_bit(3, 8, 32'h0,        32'h0, 2, 1'b1, 1'b0, 1'b0);
    sm3 = 1'b1;
    run_bit(3, 8, 32'hFFFFFFEF, 32'h0, 0, 1'b1, 1'b0, 1'b0);
    run_bit(3, 8, 32'h10,       32'h0, 0, 1'b1, 1'b1, 1'b0);
    sm3 = 1'b0;
    ps3 = 6'd9; run_bit(3, 9, 32'h1C, 32'h0, 0, 1'b1, 1'b1, 1'b0);
    ps3 = 6'd7; run_bit(3, 7, 32'h06, 32'h0, 0, 1'b1, 1'b1, 1'b1);
    ps3 = 6'd4; run_bit(3, 4, 32'h06, 32'h0, 0, 1'b1, 1'b1, 1'b1);

    ps3 = 6'd3; #1 chk("cfg3_maj", ce3, 1);
    sm3 = 1'b1; #1 chk("cfg3_single", ce3, 0);
    sm3 = 1'b0; ps3 = 6'd4; #1 chk("cfg3_ok", ce3, 0);
    ps3 = 6'd8;
    @(posedge CLK); #1;

    // Reset between the slot 3 and slot 4 captures discards the window
    run_bit(3, 8, 32'h08, 32'h0, 0, 1'b1, 1'b0, 1'b1);
    for (int j = 0; j < 4; j++) cyc(3, 1'b0, j, 1'b1);
    RST = 1'b0; #2;
    chk("mid_rst_sb", sb3, 1); chk("mid_rst_nf", nf3, 0); chk("mid_rst_sv", sv3, 0);
    RST = 1'b1;
    for (int j = 4; j < 8; j++) cyc(3, 1'b0, j, 1'b1);
    cyc(3, 1'b1, 0, 1'b0);
    chk("post_rst_hold", sb3, 1);
    run_bit(3, 8, 32'h0, 32'h0, 0, 1'b1, 1'b0, 1'b0);

    // 5-sample instance
    run_bit(5, 16, 32'hD0, 32'h0, 0, 1'b1, 1'b1, 1'b1);
    ps5 = 6'd6; #1 chk("cfg5", ce5, 1);
    run_bit(5, 6, 32'h36, 32'h0, 0, 1'b1, 1'b0, 1'b0);
    ps5 = 6'd10; #1 chk("cfg5_ok", ce5, 0);
    run_bit(5, 10, 32'hFFFFFFFF, 32'h0, 0, 1'b1, 1'b1, 1'b0);

    repeat (4) @(posedge CLK);
    #1;
    chk("drain3", q3.size(), 0);
    chk("drain5", q5.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
